// File: rtl/fmul_issue.sv
// Issue stage in front of the FP multiplier: holds operands for the whole
// operation, runs the order/accepted/done handshake and presents the product.
module fmul_issue #(
  parameter int TAG_W    = 5,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             u_order,
  input  logic             u_accepted,
  input  logic             u_done,
  output logic [31:0]      u_rs1,
  output logic [31:0]      u_rs2,
  input  logic [31:0]      u_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      rs1_q, rs2_q, data_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, capture, cnt_clr, expire;

  assign in_ready  = ~flush & ((state == S_IDLE) | ((state == S_OUT) & out_ready));
  assign accept    = in_valid & in_ready;
  assign u_order   = (state == S_ISSUE);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);
  assign u_rs1     = rs1_q;
  assign u_rs2     = rs2_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    cnt_clr   = 1'b0;
    expire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // once the unit has taken the order it will produce a done we must absorb
        if (u_accepted) begin
          cnt_clr   = 1'b1;
          state_nxt = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_nxt = u_done ? S_IDLE : S_DRAIN;
        end else if (u_done) begin
          capture   = 1'b1;
          state_nxt = S_OUT;
        end else if (cnt >= CNT_LAST) begin
          expire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (u_done) begin
          state_nxt = S_IDLE;
        end else if (cnt >= CNT_LAST) begin
          expire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_OUT: begin
        if (flush)          state_nxt = S_IDLE;
        else if (out_ready) state_nxt = accept ? S_ISSUE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q <= '0;
      rs2_q <= '0;
      tag_q <= '0;
    end else if (accept) begin
      rs1_q <= in_rs1;
      rs2_q <= in_rs2;
      tag_q <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          data_q <= '0;
    else if (capture) data_q <= u_rd;
  end

  // watchdog counter saturates so a long DRAIN can never wrap past the limit
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= '0;
    else if (((state == S_WAIT) || (state == S_DRAIN)) && (cnt != CNT_MAX))
      cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)         err <= 1'b0;
    else if (expire) err <= 1'b1;
  end

endmodule

// File: tb/tb_fmul_issue.sv
// Directed bench for fmul_issue with a stub multiplier whose products are
// a hand-computed lookup on the held operands.
module tb_fmul_issue;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready;
  logic [31:0]      in_rs1, in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             u_order, u_accepted, u_done;
  logic [31:0]      u_rs1, u_rs2, u_rd;
  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy, err;

  logic acc_en  = 1'b1;
  logic done_en = 1'b1;
  int   dcnt    = 0;
  int   xfers   = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fmul_issue #(.TAG_W(TAG_W), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .u_order(u_order), .u_accepted(u_accepted), .u_done(u_done),
    .u_rs1(u_rs1), .u_rs2(u_rs2), .u_rd(u_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .busy(busy), .err(err)
  );

  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: prod = 32'h40C00000;
      {32'h3FC00000, 32'hC0000000}: prod = 32'hC0400000;
      {32'h00000000, 32'h7F000000}: prod = 32'h00000000;
      {32'h3F800000, 32'h41200000}: prod = 32'h41200000;
      default:                      prod = 32'hDEADBEEF;
    endcase
  endfunction

  // stub unit: takes the order combinationally, answers three cycles later
  assign u_accepted = u_order & acc_en;
  assign u_done     = done_en & (dcnt == 1);
  always_comb u_rd = prod(u_rs1, u_rs2);

  always @(posedge clk) begin
    if (u_order && u_accepted) dcnt <= 3;
    else if (dcnt != 0)        dcnt <= dcnt - 1;
    if (out_valid && out_ready && !flush) xfers <= xfers + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    in_valid = 1'b1; in_rs1 = a; in_rs2 = b; in_tag = t;
    #1;
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_rs1 = 32'hFFFFFFFF; in_rs2 = 32'hFFFFFFFF; in_tag = '1;
    chk("order_t1", {31'd0, u_order}, 32'd1);
  endtask

  // caller sits at T0+1; returns the cycle index where out_valid appears
  task automatic wait_out(input logic [31:0] a, input logic [31:0] b, output int cyc);
    int unstable = 0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      if (u_rs1 !== a || u_rs2 !== b) unstable++;
      tick();
      cyc++;
    end
    chk("op_hold", unstable, 0);
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int cyc, x0, bad;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    tick(); tick();
    chk("rst_order", {31'd0, u_order}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_data",  out_data, 32'd0);
    rst = 1'b0;
    tick();

    // flush in IDLE blocks acceptance
    in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("idle_flush_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);

    // basic op, latency 5
    out_ready = 1'b1;
    do_accept(32'h40000000, 32'h40400000, 5'd3);
    chk("basic_rs1", u_rs1, 32'h40000000);
    wait_out(32'h40000000, 32'h40400000, cyc);
    chk("basic_lat", cyc, 5);
    chk("basic_data", out_data, 32'h40C00000);
    chk("basic_tag", {27'd0, out_tag}, 32'd3);
    x0 = xfers;
    tick();
    chk("basic_drop", {31'd0, out_valid}, 32'd0);
    chk("basic_xfer", xfers - x0, 1);

    // back-to-back: second op accepted in first op's OUT cycle
    do_accept(32'h3FC00000, 32'hC0000000, 5'd1);
    wait_out(32'h3FC00000, 32'hC0000000, cyc);
    chk("b2b1_data", out_data, 32'hC0400000);
    chk("b2b1_tag", {27'd0, out_tag}, 32'd1);
    in_valid = 1'b1; in_rs1 = 32'h00000000; in_rs2 = 32'h7F000000; in_tag = 5'd2;
    #1;
    chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_rs1 = 32'hFFFFFFFF; in_rs2 = 32'hFFFFFFFF;
    chk("b2b_order", {31'd0, u_order}, 32'd1);
    wait_out(32'h00000000, 32'h7F000000, cyc);
    chk("b2b_spacing", cyc, 5);
    chk("b2b2_data", out_data, 32'h00000000);
    chk("b2b2_tag", {27'd0, out_tag}, 32'd2);
    tick();

    // backpressure for 10 cycles
    out_ready = 1'b0;
    do_accept(32'h40000000, 32'h40400000, 5'd7);
    wait_out(32'h40000000, 32'h40400000, cyc);
    x0 = xfers; bad = 0;
    in_valid = 1'b1; in_rs1 = 32'h3F800000; in_rs2 = 32'h41200000;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!out_valid || out_data !== 32'h40C00000 || out_tag !== 5'd7 || in_ready) bad++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_hold", bad, 0);
    chk("bp_noxfer", xfers - x0, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_release", {31'd0, out_valid}, 32'd0);
    chk("bp_one_xfer", xfers - x0, 1);

    // flush in WAIT at T0+2
    do_accept(32'h40000000, 32'h40400000, 5'd4);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b1;
    #1;
    chk("fw_t3_ready", {31'd0, in_ready}, 32'd0);
    chk("fw_t3_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("fw_t4_done", {31'd0, u_done}, 32'd1);
    chk("fw_t4_ready", {31'd0, in_ready}, 32'd0);
    chk("fw_t4_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("fw_t5_busy", {31'd0, busy}, 32'd0);
    chk("fw_t5_valid", {31'd0, out_valid}, 32'd0);
    do_accept(32'h3F800000, 32'h41200000, 5'd9);
    wait_out(32'h3F800000, 32'h41200000, cyc);
    chk("fw_next_lat", cyc, 5);
    chk("fw_next_data", out_data, 32'h41200000);
    chk("fw_next_tag", {27'd0, out_tag}, 32'd9);
    tick();

    // flush in ISSUE while the unit refuses the order
    acc_en = 1'b0;
    do_accept(32'h40000000, 32'h40400000, 5'd5);
    tick();
    chk("fi_order_held", {31'd0, u_order}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fi_order_drop", {31'd0, u_order}, 32'd0);
    chk("fi_busy", {31'd0, busy}, 32'd0);
    acc_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid || busy) bad++;
      tick();
    end
    chk("fi_quiet", bad, 0);

    // flush in OUT with out_ready high: transfer must not happen
    do_accept(32'h3FC00000, 32'hC0000000, 5'd6);
    out_ready = 1'b0;
    wait_out(32'h3FC00000, 32'hC0000000, cyc);
    x0 = xfers;
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fo_drop", {31'd0, out_valid}, 32'd0);
    chk("fo_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("fo_noxfer", xfers - x0, 0);

    // watchdog: unit never answers
    done_en = 1'b0;
    do_accept(32'h40000000, 32'h40400000, 5'd8);
    for (int i = 0; i < 8; i++) tick();
    chk("wd_t9_err", {31'd0, err}, 32'd0);
    chk("wd_t9_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("wd_t10_err", {31'd0, err}, 32'd1);
    chk("wd_t10_busy", {31'd0, busy}, 32'd0);
    done_en = 1'b1;
    tick();

    // operation continues with err sticky
    do_accept(32'h3F800000, 32'h41200000, 5'd10);
    wait_out(32'h3F800000, 32'h41200000, cyc);
    chk("wd_after_data", out_data, 32'h41200000);
    chk("wd_err_sticky", {31'd0, err}, 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err", {31'd0, err}, 32'd0);
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    chk("rst2_data", out_data, 32'd0);
    chk("rst2_tag", {27'd0, out_tag}, 32'd0);
    chk("rst2_rs1", u_rs1, 32'd0);
    chk("rst2_rs2", u_rs2, 32'd0);
    chk("rst2_order", {31'd0, u_order}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
